// File: rtl/bf16_div_seq.sv
// Iterative bfloat16 divider: restoring division, one quotient bit per clock, valid/ready on both sides.
// Optional macro BF16_DIV_ROUND_EN adds a guard iteration and round-to-nearest-even in NORM.
module bf16_div_seq #(
    parameter int DATA_WIDTH  = 16,
    parameter int EXP_WIDTH   = 8,
    parameter int FRAC_WIDTH  = 7,
    parameter int ERROR_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in1,
    input  logic [DATA_WIDTH-1:0]  in2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out,
    output logic [ERROR_WIDTH-1:0] error
);

    localparam int MANT_W  = FRAC_WIDTH + 1;
    localparam int EW      = EXP_WIDTH + 2;
    localparam int BIAS    = (1 << (EXP_WIDTH - 1)) - 1;
    localparam int EXP_MAX = (1 << EXP_WIDTH) - 1;
`ifdef BF16_DIV_ROUND_EN
    localparam int GUARD = 1;
`else
    localparam int GUARD = 0;
`endif
    localparam int QW    = MANT_W + 1 + GUARD;
    localparam int ITERS = QW;

    localparam logic [EW-1:0]        BIAS_E  = EW'(BIAS);
    localparam logic [EW-1:0]        ONE_E   = EW'(1);
    localparam logic signed [EW-1:0] EMAX_S  = EW'(EXP_MAX);
    localparam logic [3:0]           LAST_IT = 4'(ITERS - 1);

    localparam logic [ERROR_WIDTH-1:0] ERR_OK  = ERROR_WIDTH'(0);
    localparam logic [ERROR_WIDTH-1:0] ERR_OVF = ERROR_WIDTH'(1);
    localparam logic [ERROR_WIDTH-1:0] ERR_UNF = ERROR_WIDTH'(2);
    localparam logic [ERROR_WIDTH-1:0] ERR_DBZ = ERROR_WIDTH'(3);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t                  state_q;
    logic                    sign_q;
    logic signed [EW-1:0]    exp_q;
    logic [MANT_W-1:0]       m2_q;
    logic [MANT_W:0]         r_q;
    logic [QW-1:0]           q_q;
    logic [3:0]              cnt_q;
    logic                    special_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_q;
    logic [ERROR_WIDTH-1:0]  err_q;

    logic                    sign_a;
    logic                    zero1;
    logic                    zero2;
    logic [EW-1:0]           exp_a;

    logic                    ge;
    logic [MANT_W:0]         r_rem;
    logic [MANT_W:0]         r_d;
    logic [QW-1:0]           q_d;

    logic                    lead;
    logic [FRAC_WIDTH-1:0]   frac_sel;
    logic [FRAC_WIDTH-1:0]   frac_n;
    logic signed [EW-1:0]    exp_n;
    logic [DATA_WIDTH-1:0]   norm_out_d;
    logic [ERROR_WIDTH-1:0]  norm_err_d;
`ifdef BF16_DIV_ROUND_EN
    logic                    guard_b;
    logic                    sticky;
    logic                    carry;
`endif

    always_comb begin
        sign_a = in1[DATA_WIDTH-1] ^ in2[DATA_WIDTH-1];
        zero1  = (in1[DATA_WIDTH-2:0] == '0);
        zero2  = (in2[DATA_WIDTH-2:0] == '0);
        exp_a  = {2'b00, in1[DATA_WIDTH-2 -: EXP_WIDTH]}
               - {2'b00, in2[DATA_WIDTH-2 -: EXP_WIDTH]} + BIAS_E;
    end

    // One restoring step; the shifted remainder stays below 2*m2 so MANT_W+1 bits suffice.
    always_comb begin
        ge    = (r_q >= {1'b0, m2_q});
        r_rem = ge ? (r_q - {1'b0, m2_q}) : r_q;
        r_d   = {r_rem[MANT_W-1:0], 1'b0};
        q_d   = {q_q[QW-2:0], ge};
    end

    always_comb begin
        lead     = q_q[QW-1];
        frac_sel = lead ? q_q[QW-2 -: FRAC_WIDTH] : q_q[QW-3 -: FRAC_WIDTH];
        exp_n    = lead ? exp_q : exp_q - ONE_E;
        frac_n   = frac_sel;
`ifdef BF16_DIV_ROUND_EN
        // Bits below the guard (q[0] when the lead bit is set) fold into sticky with the remainder.
        guard_b  = lead ? q_q[1] : q_q[0];
        sticky   = (r_q != '0) | (lead & q_q[0]);
        {carry, frac_n} = {1'b0, frac_sel}
                        + {{FRAC_WIDTH{1'b0}}, guard_b & (sticky | frac_sel[0])};
        exp_n    = exp_n + {{(EW-1){1'b0}}, carry};
`endif
        if (exp_n >= EMAX_S) begin
            norm_out_d = {sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
            norm_err_d = ERR_OVF;
        end else if (exp_n[EW-1] || exp_n == '0) begin
            norm_out_d = {sign_q, {(DATA_WIDTH-1){1'b0}}};
            norm_err_d = ERR_UNF;
        end else begin
            norm_out_d = {sign_q, exp_n[EXP_WIDTH-1:0], frac_n};
            norm_err_d = ERR_OK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            m2_q        <= '0;
            r_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            special_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            err_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q     <= sign_a;
                        exp_q      <= exp_a;
                        m2_q       <= {1'b1, in2[FRAC_WIDTH-1:0]};
                        r_q        <= {2'b01, in1[FRAC_WIDTH-1:0]};
                        q_q        <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        special_q  <= zero1 | zero2;
                        // Specials skip DIV and pass through NORM untouched, giving latency 1.
                        if (zero1) begin
                            out_q   <= {sign_a, {(DATA_WIDTH-1){1'b0}}};
                            err_q   <= ERR_OK;
                            state_q <= NORM;
                        end else if (zero2) begin
                            out_q   <= {sign_a, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
                            err_q   <= ERR_DBZ;
                            state_q <= NORM;
                        end else begin
                            state_q <= DIV;
                        end
                    end
                end
                DIV: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST_IT) begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    if (!special_q) begin
                        out_q <= norm_out_d;
                        err_q <= norm_err_d;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign error     = err_q;

endmodule

// File: tb/tb_bf16_div_seq.sv
// Directed bench for bf16_div_seq; expected results and latencies follow BF16_DIV_ROUND_EN.
module tb_bf16_div_seq;

`ifdef BF16_DIV_ROUND_EN
    localparam int          LAT_N = 11;
    localparam logic [15:0] THIRD = 16'h3EAB;
`else
    localparam int          LAT_N = 10;
    localparam logic [15:0] THIRD = 16'h3EAA;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic [1:0]  error;

    int n_cmp = 0;
    int n_bad = 0;

    bf16_div_seq #(
        .DATA_WIDTH (16),
        .EXP_WIDTH  (8),
        .FRAC_WIDTH (7),
        .ERROR_WIDTH(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in1      (in1),
        .in2      (in2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Stimulus only: launch one operation and count edges until out_valid (bounded).
    task automatic send_and_wait(input logic [15:0] a, input logic [15:0] b, output int lat);
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out !== 16'h0000) begin n_bad++; $display("FAIL reset_out got %h want 0000", out); end
        n_cmp++; if (error !== 2'b00) begin n_bad++; $display("FAIL reset_error got %b want 00", error); end
    endtask

    task automatic test_normal();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [15:0] vq [3];
        int lat;
        va[0] = 16'h40C0; vb[0] = 16'h4000; vq[0] = 16'h4040;
        va[1] = 16'h3F80; vb[1] = 16'h4040; vq[1] = THIRD;
        va[2] = 16'hBFC0; vb[2] = 16'h3F00; vq[2] = 16'hC040;
        for (int i = 0; i < 3; i++) begin
            send_and_wait(va[i], vb[i], lat);
            n_cmp++; if (lat !== LAT_N) begin n_bad++; $display("FAIL norm%0d_latency got %0d want %0d", i, lat, LAT_N); end
            n_cmp++; if (out !== vq[i]) begin n_bad++; $display("FAIL norm%0d_out got %h want %h", i, out, vq[i]); end
            n_cmp++; if (error !== 2'b00) begin n_bad++; $display("FAIL norm%0d_error got %b want 00", i, error); end
            release_result();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL norm%0d_valid_drop got %b want 0", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL norm%0d_in_ready got %b want 1", i, in_ready); end
        end
    endtask

    task automatic test_special();
        int lat;
        send_and_wait(16'h3F80, 16'h0000, lat);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL dbz_latency got %0d want 1", lat); end
        n_cmp++; if (out !== 16'h7F80) begin n_bad++; $display("FAIL dbz_out got %h want 7f80", out); end
        n_cmp++; if (error !== 2'b11) begin n_bad++; $display("FAIL dbz_error got %b want 11", error); end
        release_result();
        send_and_wait(16'h0000, 16'hC000, lat);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL zero_latency got %0d want 1", lat); end
        n_cmp++; if (out !== 16'h8000) begin n_bad++; $display("FAIL zero_out got %h want 8000", out); end
        n_cmp++; if (error !== 2'b00) begin n_bad++; $display("FAIL zero_error got %b want 00", error); end
        release_result();
    endtask

    task automatic test_range();
        int lat;
        send_and_wait(16'h7F00, 16'h3F00, lat);
        n_cmp++; if (out !== 16'h7F80) begin n_bad++; $display("FAIL ovf_out got %h want 7f80", out); end
        n_cmp++; if (error !== 2'b01) begin n_bad++; $display("FAIL ovf_error got %b want 01", error); end
        release_result();
        send_and_wait(16'h0080, 16'h4000, lat);
        n_cmp++; if (lat !== LAT_N) begin n_bad++; $display("FAIL unf_latency got %0d want %0d", lat, LAT_N); end
        n_cmp++; if (out !== 16'h0000) begin n_bad++; $display("FAIL unf_out got %h want 0000", out); end
        n_cmp++; if (error !== 2'b10) begin n_bad++; $display("FAIL unf_error got %b want 10", error); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        send_and_wait(16'h40C0, 16'h4000, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold%0d_valid got %b want 1", i, out_valid); end
            n_cmp++; if (out !== 16'h4040) begin n_bad++; $display("FAIL hold%0d_out got %h want 4040", i, out); end
            n_cmp++; if (error !== 2'b00) begin n_bad++; $display("FAIL hold%0d_error got %b want 00", i, error); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold%0d_in_ready got %b want 0", i, in_ready); end
        end
        // New operands are already valid on the release edge; they must only be taken one edge later.
        in1 = 16'hBFC0;
        in2 = 16'h3F00;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_drop got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_accepted got %b want 0", in_ready); end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++; if (lat !== LAT_N) begin n_bad++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT_N); end
        n_cmp++; if (out !== 16'hC040) begin n_bad++; $display("FAIL b2b_out got %h want c040", out); end
        release_result();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int seen;
        in1 = 16'h40C0;
        in2 = 16'h4000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out !== 16'h0000) begin n_bad++; $display("FAIL rstmid_out got %h want 0000", out); end
        n_cmp++; if (error !== 2'b00) begin n_bad++; $display("FAIL rstmid_error got %b want 00", error); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_stale_valid got %0d want 0", seen); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready_after got %b want 1", in_ready); end
        send_and_wait(16'h3F80, 16'h4040, lat);
        n_cmp++; if (lat !== LAT_N) begin n_bad++; $display("FAIL rstmid_next_latency got %0d want %0d", lat, LAT_N); end
        n_cmp++; if (out !== THIRD) begin n_bad++; $display("FAIL rstmid_next_out got %h want %h", out, THIRD); end
        release_result();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in1 = '0;
        in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_normal();
        test_special();
        test_range();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
